// File: rtl/cyclic_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module : cyclic_shift_pipe
// Brief  : Pipelined multi-lane barrel rotator, one register per log2 stage.
// Rev    : 1.0
// ============================================================================
module cyclic_shift_pipe #(
  parameter  int WIDTH  = 4,
  parameter  int LANES  = 1,
  localparam int SW     = $clog2(WIDTH),
  localparam int NSTAGE = SW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES*SW-1:0]    in_shift,
  input  logic                   in_dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data
);

  localparam logic [SW:0]   c_width_ext = (SW+1)'(WIDTH);
  localparam logic [SW-1:0] c_width_lo  = SW'(WIDTH);

  logic [LANES*SW-1:0]                 w_eff;
  logic [NSTAGE-1:0]                   r_valid;
  logic [NSTAGE-1:0][LANES*WIDTH-1:0]  r_data;
  logic [NSTAGE-1:0][LANES*SW-1:0]     r_amt;
  logic [NSTAGE-1:0]                   w_load;
  logic [NSTAGE-1:0]                   w_v_in;
  logic [NSTAGE-1:0][LANES*WIDTH-1:0]  w_d_in;
  logic [NSTAGE-1:0][LANES*WIDTH-1:0]  w_d_out;
  logic [NSTAGE-1:0][LANES*SW-1:0]     w_a_in;
  logic [NSTAGE-1:0][LANES*SW-1:0]     w_a_out;
  logic                                w_unused;

  // Amounts are below 2*WIDTH, so one conditional subtract gives s mod WIDTH.
  for (genvar k = 0; k < LANES; k++) begin : g_eff
    logic [SW-1:0] w_s;
    logic [SW-1:0] w_mod;
    assign w_s   = in_shift[k*SW +: SW];
    assign w_mod = ({1'b0, w_s} >= c_width_ext) ? w_s - c_width_lo : w_s;
    assign w_eff[k*SW +: SW] = (in_dir && (w_mod != '0)) ? c_width_lo - w_mod : w_mod;
  end

  for (genvar j = 0; j < NSTAGE; j++) begin : g_stage
    localparam int c_rot = (1 << j) % WIDTH;

    if (j == 0) begin : g_first
      assign w_v_in[j] = in_valid;
      assign w_d_in[j] = in_data;
      assign w_a_in[j] = w_eff;
    end else begin : g_next
      assign w_v_in[j] = r_valid[j-1];
      assign w_d_in[j] = r_data[j-1];
      assign w_a_in[j] = r_amt[j-1];
    end

    // A stage may load whenever some stage at or after it is empty.
    assign w_load[j] = out_ready || !(&r_valid[NSTAGE-1:j]);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [WIDTH-1:0] w_word;
      logic [SW-1:0]    w_amt;
      assign w_word = w_d_in[j][k*WIDTH +: WIDTH];
      assign w_amt  = w_a_in[j][k*SW +: SW];
      assign w_d_out[j][k*WIDTH +: WIDTH] =
          w_amt[0] ? {w_word[c_rot-1:0], w_word[WIDTH-1:c_rot]} : w_word;
      assign w_a_out[j][k*SW +: SW] = w_amt >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_amt   <= '0;
    end else begin
      for (int j = 0; j < NSTAGE; j++) begin
        if (w_load[j]) begin
          r_valid[j] <= w_v_in[j];
          if (w_v_in[j]) begin
            r_data[j] <= w_d_out[j];
            r_amt[j]  <= w_a_out[j];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[NSTAGE-1];
  assign out_data  = r_data[NSTAGE-1];

  // The last stage's leftover amount is always zero and feeds nothing.
  assign w_unused = ^r_amt[NSTAGE-1];

endmodule
`default_nettype wire
